// File: rtl/ozy_req_ctrl.sv
// Request sequencer in front of the OZY RAM: valid/ready request in, setup/strobe/release access, valid/ready response out.
// Optional write readback check is compiled in with `define OZY_CTRL_RDBACK_EN.
module ozy_req_ctrl #(
    parameter int word_size     = 21,
    parameter int word_quantity = 33,
    parameter int AW            = $clog2(word_quantity)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [AW-1:0]        req_addr,
    input  logic [word_size-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [word_size-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_we,
    output logic                 mem_type,
    output logic [word_size-1:0] mem_data_in,
    input  logic [word_size-1:0] mem_data_out
);

`ifdef OZY_CTRL_RDBACK_EN
    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, RELEASE, RESP, RB_SETUP, RB_STROBE, RB_RELEASE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, RELEASE, RESP
    } state_t;
`endif

    state_t state;

    function automatic logic addr_in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(word_quantity);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            mem_we      <= 1'b0;
            mem_type    <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        mem_addr    <= req_addr;
                        mem_type    <= req_write;
                        mem_data_in <= req_wdata;
                        req_ready   <= 1'b0;
                        rsp_rdata   <= '0;
                        // Out-of-range requests never touch the RAM.
                        if (!addr_in_range(req_addr)) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            rsp_err <= 1'b0;
                            state   <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    mem_we <= 1'b1;
                    state  <= STROBE;
                end
                STROBE: begin
                    mem_we <= 1'b0;
                    state  <= RELEASE;
                end
                RELEASE: begin
`ifdef OZY_CTRL_RDBACK_EN
                    if (mem_type) begin
                        mem_type <= 1'b0;
                        state    <= RB_SETUP;
                    end else begin
                        rsp_rdata <= mem_data_out;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
`else
                    if (!mem_type) begin
                        rsp_rdata <= mem_data_out;
                    end
                    rsp_valid <= 1'b1;
                    state     <= RESP;
`endif
                end
`ifdef OZY_CTRL_RDBACK_EN
                RB_SETUP: begin
                    mem_we <= 1'b1;
                    state  <= RB_STROBE;
                end
                RB_STROBE: begin
                    mem_we <= 1'b0;
                    state  <= RB_RELEASE;
                end
                RB_RELEASE: begin
                    // Write response carries no data; only flag a failed readback.
                    rsp_err   <= (mem_data_out != mem_data_in);
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    mem_we    <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ozy_req_ctrl.sv
// Bench for ozy_req_ctrl: transaction-level model with per-cycle compare, plus directed literal expectations.
`timescale 1ns/1ps
module tb_ozy_req_ctrl;
    localparam int W  = 21;
    localparam int Q  = 33;
    localparam int AW = $clog2(Q);
`ifdef OZY_CTRL_RDBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int LAT_RD  = 4;
    localparam int LAT_WR  = RB ? 7 : 4;
    localparam int LAT_ERR = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [W-1:0]  req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [W-1:0]  rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_type;
    logic [W-1:0]  mem_data_in;
    logic [W-1:0]  mem_data_out;

    always #5 clk = ~clk;

    ozy_req_ctrl #(.word_size(W), .word_quantity(Q)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_type(mem_type),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // Stand-in RAM: write lands on the edge that closes a write strobe.
    logic [W-1:0] ozy [0:63];
    always @(posedge clk) if (mem_we && mem_type) ozy[mem_addr] <= mem_data_in;
    assign mem_data_out = ozy[mem_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one request in flight, expected response computed at accept.
    logic [W-1:0]  model_mem [0:Q-1];
    bit            busy = 1'b0;
    int            ecnt = 0;
    int            acc_edge = 0;
    int            exp_lat = 0;
    int            we_cnt = 0;
    bit            exp_w, exp_err;
    logic [AW-1:0] exp_addr;
    logic [W-1:0]  exp_wdata, exp_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 1'b0;
        end else begin
            ecnt++;
            if (mem_we) we_cnt++;
            if (busy) begin
                if (rsp_valid && rsp_ready) busy = 1'b0;
            end else if (req_valid && req_ready) begin
                busy      = 1'b1;
                acc_edge  = ecnt;
                exp_w     = req_write;
                exp_addr  = req_addr;
                exp_wdata = req_wdata;
                exp_err   = (int'(req_addr) >= Q);
                exp_rdata = '0;
                if (!exp_err) begin
                    if (req_write) model_mem[req_addr] = req_wdata;
                    else           exp_rdata = model_mem[req_addr];
                end
                exp_lat = exp_err ? LAT_ERR : (req_write ? LAT_WR : LAT_RD);
            end
        end
    end

    always @(negedge clk) begin : cmp
        int   ph;
        logic we_exp;
        if (!busy) begin
            chk("idle_req_ready", req_ready, 1);
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_mem_we", mem_we, 0);
        end else begin
            ph     = ecnt - acc_edge + 1;
            we_exp = !exp_err && (ph == 2 || (RB && exp_w && ph == 5));
            chk("busy_req_ready", req_ready, 0);
            chk("mem_we", mem_we, we_exp);
            chk("rsp_valid", rsp_valid, ph >= exp_lat);
            chk("mem_addr", mem_addr, exp_addr);
            if (ph >= exp_lat) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_err", rsp_err, exp_err);
            end
            if (!exp_err && ph <= 3) begin
                chk("mem_type", mem_type, exp_w);
                if (exp_w) chk("mem_data_in", mem_data_in, exp_wdata);
            end
        end
    end

    task automatic do_req(input logic w, input int a, input logic [W-1:0] d, input int hold,
                          output logic [W-1:0] rd, output logic er, output int lat);
        int n;
        logic [W-1:0] rd0;
        rd = '0; er = 1'b0; lat = 0;
        @(negedge clk); #1;
        if (hold > 0) rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = w; req_addr = AW'(a); req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0; rsp_ready = 1'b1;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            rsp_ready = 1'b1;
            return;
        end
        rd0 = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            #1;
            req_valid = 1'b1; req_write = 1'b1; req_addr = '0; req_wdata = '1;
            @(negedge clk);
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rsp_rdata", rsp_rdata, rd0);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_mem_we", mem_we, 0);
        end
        rd = rsp_rdata;
        er = rsp_err;
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rd;
        logic         er;
        int           lat, we_before, n;
        for (int i = 0; i < 64; i++) ozy[i] = '0;
        for (int i = 0; i < Q; i++) model_mem[i] = '0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_type", mem_type, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data_in", mem_data_in, 0);
        #1 rst_n = 1'b1;

        do_req(1'b1, 5, 21'd13, 0, rd, er, lat);
        chk("wr5_lat", lat, LAT_WR); chk("wr5_err", er, 0); chk("wr5_rdata", rd, 0);
        do_req(1'b0, 5, '0, 0, rd, er, lat);
        chk("rd5_lat", lat, LAT_RD); chk("rd5_rdata", rd, 21'h00000D); chk("rd5_err", er, 0);

        do_req(1'b1, 24, 21'd15, 0, rd, er, lat);
        chk("wr24_err", er, 0);
        do_req(1'b0, 24, '0, 0, rd, er, lat);
        chk("rd24_rdata", rd, 21'h00000F);
        do_req(1'b0, 5, '0, 0, rd, er, lat);
        chk("rd5b_rdata", rd, 21'h00000D);

        do_req(1'b1, 32, 21'h1FFFFF, 0, rd, er, lat);
        chk("wr32_err", er, 0);
        do_req(1'b0, 32, '0, 0, rd, er, lat);
        chk("rd32_rdata", rd, 21'h1FFFFF);

        we_before = we_cnt;
        do_req(1'b1, 33, 21'h00007, 0, rd, er, lat);
        chk("wr33_lat", lat, LAT_ERR); chk("wr33_err", er, 1); chk("wr33_rdata", rd, 0);
        chk("wr33_no_strobe", we_cnt - we_before, 0);
        do_req(1'b0, 63, '0, 0, rd, er, lat);
        chk("rd63_err", er, 1);
        do_req(1'b0, 32, '0, 0, rd, er, lat);
        chk("rd32b_rdata", rd, 21'h1FFFFF);

        do_req(1'b0, 24, '0, 10, rd, er, lat);
        chk("stall_rd24_rdata", rd, 21'h00000F);
        @(negedge clk);
        chk("stall_release_idle", req_ready, 1);

        @(negedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(10); req_wdata = 21'h5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_we && n < 10) begin @(negedge clk); n++; end
        chk("reach_strobe", mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        @(negedge clk); @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_rsp_valid", rsp_valid, 0);

        do_req(1'b0, 5, '0, 0, rd, er, lat);
        chk("post_rst_rd5", rd, 21'h00000D);
        do_req(1'b1, 0, 21'h0ABCDE, 0, rd, er, lat);
        chk("wr0_lat", lat, LAT_WR);
        do_req(1'b0, 0, '0, 0, rd, er, lat);
        chk("rd0_rdata", rd, 21'h0ABCDE);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
